// File: rtl/gate_vector_checker.sv
// Clocked stimulus/check sequencer for a two-input primitive gate bank.
// Walks (a,b) through 00,10,01,11, samples the seven gate outputs after a hold window and scores them.
module gate_vector_checker #(
   parameter int HOLD_CYCLES = 4,
   parameter int HOLD_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] gate_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] err_mask,
   output logic [2:0] err_count,
   output logic [1:0] first_fail_vec
);

   generate
      if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold_cycles
         $error("gate_vector_checker: HOLD_CYCLES must be in 1..255");
      end
      if (HOLD_W < $clog2(HOLD_CYCLES + 1)) begin : g_bad_hold_w
         $error("gate_vector_checker: HOLD_W too narrow for HOLD_CYCLES");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   state_t            state;
   logic [1:0]        vec;
   logic [HOLD_W-1:0] hold_cnt;

   logic [6:0] expected;
   logic [6:0] diff;
   logic       any_diff;
   logic [2:0] err_count_nx;
   logic [1:0] vec_nx;

   // Bit order matches gate_in: and, or, nor, nand, xnor, xor, not (a_out = vec[0], b_out = vec[1]).
   function automatic logic [6:0] expected_out(input logic [1:0] v);
      logic a;
      logic b;
      a = v[0];
      b = v[1];
      return {~a, a ^ b, ~(a ^ b), ~(a & b), ~(a | b), a | b, a & b};
   endfunction

   always_comb begin
      expected     = expected_out(vec);
      diff         = gate_in ^ expected;
      any_diff     = |diff;
      err_count_nx = err_count + {2'b00, any_diff};
      vec_nx       = vec + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         vec            <= 2'd0;
         hold_cnt       <= '0;
         a_out          <= 1'b0;
         b_out          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_mask       <= 7'd0;
         err_count      <= 3'd0;
         first_fail_vec <= 2'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               a_out <= 1'b0;
               b_out <= 1'b0;
               if (start) begin
                  state          <= DRIVE;
                  vec            <= 2'd0;
                  hold_cnt       <= '0;
                  busy           <= 1'b1;
                  pass           <= 1'b0;
                  err_mask       <= 7'd0;
                  err_count      <= 3'd0;
                  first_fail_vec <= 2'd0;
               end
            end
            DRIVE: begin
               hold_cnt <= hold_cnt + 1'b1;
               if (hold_cnt == HOLD_LAST) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               err_mask <= err_mask | diff;
               if (any_diff) begin
                  err_count <= err_count_nx;
                  if (err_count == 3'd0) begin
                     first_fail_vec <= vec;
                  end
               end
               if (vec == 2'd3) begin
                  // pass must reflect this final sample, so use the updated count.
                  state <= DONE;
                  done  <= 1'b1;
                  pass  <= (err_count_nx == 3'd0);
               end else begin
                  state    <= DRIVE;
                  vec      <= vec_nx;
                  hold_cnt <= '0;
                  a_out    <= vec_nx[0];
                  b_out    <= vec_nx[1];
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               a_out <= 1'b0;
               b_out <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a behavioural gate bank with injectable faults feeds the checker,
// expected run results are queued at start and compared when done pulses.
module tb_gate_vector_checker;

   logic       clk;
   logic       rst;
   logic       start;
   logic [6:0] gate_in;
   logic       a_out;
   logic       b_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [6:0] err_mask;
   logic [2:0] err_count;
   logic [1:0] first_fail_vec;

   logic       start1;
   logic [6:0] gate_in1;
   logic       a_out1;
   logic       b_out1;
   logic       busy1;
   logic       done1;
   logic       pass1;
   logic [6:0] err_mask1;
   logic [2:0] err_count1;
   logic [1:0] first_fail_vec1;

   int total;
   int bad;
   int fault_mode;

   // {pass, err_mask, err_count, first_fail_vec}
   logic [12:0] exp_q[$];
   logic [12:0] exp_q1[$];

   gate_vector_checker #(.HOLD_CYCLES(4), .HOLD_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .gate_in(gate_in),
      .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
      .err_mask(err_mask), .err_count(err_count), .first_fail_vec(first_fail_vec)
   );

   gate_vector_checker #(.HOLD_CYCLES(1), .HOLD_W(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .gate_in(gate_in1),
      .a_out(a_out1), .b_out(b_out1), .busy(busy1), .done(done1), .pass(pass1),
      .err_mask(err_mask1), .err_count(err_count1), .first_fail_vec(first_fail_vec1)
   );

   function automatic logic [6:0] gate_bank(input logic a, input logic b, input int mode);
      logic [6:0] g;
      g = {~a, a ^ b, ~(a ^ b), ~(a & b), ~(a | b), a | b, a & b};
      if (mode == 1) g[3] = 1'b1;
      if (mode == 2) g = {g[6], g[4], g[5], g[3:0]};
      return g;
   endfunction

   assign gate_in  = gate_bank(a_out, b_out, fault_mode);
   assign gate_in1 = gate_bank(a_out1, b_out1, 0);

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver / scenario tasks ----------------
   task automatic run_check(input int mode, input bit check_seq, input logic [12:0] expv);
      int lat;
      logic [1:0] v;
      logic [12:0] e;
      fault_mode = mode;
      exp_q.push_back(expv);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         if (check_seq) begin
            v = 2'(k / 5);
            total++;
            if ({a_out, b_out, busy} !== {v[0], v[1], 1'b1}) begin
               bad++;
               $display("FAIL seq k=%0d: a,b,busy=%b%b%b required %b%b1", k, a_out, b_out, busy, v[0], v[1]);
            end
         end
         @(negedge clk);
      end
      total++;
      if (lat !== 20) begin
         bad++;
         $display("FAIL latency: got %0d required 20", lat);
      end
      if (lat >= 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if ({pass, err_mask, err_count, first_fail_vec} !== e) begin
            bad++;
            $display("FAIL result mode=%0d: pass=%b mask=%b cnt=%0d ffv=%0d required pass=%b mask=%b cnt=%0d ffv=%0d",
                     mode, pass, err_mask, err_count, first_fail_vec, e[12], e[11:5], e[4:2], e[1:0]);
         end
         @(negedge clk);
         total++;
         if ({busy, done, a_out, b_out} !== 4'b0000 || {pass, err_mask, err_count, first_fail_vec} !== e) begin
            bad++;
            $display("FAIL idle_after: busy=%b done=%b ab=%b%b pass=%b mask=%b required idle with results held",
                     busy, done, a_out, b_out, pass, err_mask);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({a_out, b_out, busy, done, pass, err_mask, err_count, first_fail_vec} !== 16'd0) begin
         bad++;
         $display("FAIL reset: outputs=%h required 0",
                  {a_out, b_out, busy, done, pass, err_mask, err_count, first_fail_vec});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_good_run();
      run_check(0, 1'b1, {1'b1, 7'b0000000, 3'd0, 2'd0});
   endtask

   task automatic test_nand_fault();
      run_check(1, 1'b0, {1'b0, 7'b0001000, 3'd1, 2'd3});
   endtask

   task automatic test_xor_swap();
      run_check(2, 1'b0, {1'b0, 7'b0110000, 3'd4, 2'd0});
   endtask

   task automatic test_start_ignored();
      int first_done;
      int n_done;
      logic [12:0] e;
      fault_mode = 0;
      exp_q.push_back({1'b1, 7'b0000000, 3'd0, 2'd0});
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      first_done = -1;
      n_done = 0;
      total++;
      if ({err_mask, err_count, first_fail_vec, pass} !== 13'd0) begin
         bad++;
         $display("FAIL clear_on_start: mask=%b cnt=%0d ffv=%0d pass=%b required all 0",
                  err_mask, err_count, first_fail_vec, pass);
      end
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) begin
            n_done++;
            if (first_done < 0) begin
               first_done = k;
               e = exp_q.pop_front();
               total++;
               if ({pass, err_mask, err_count, first_fail_vec} !== e) begin
                  bad++;
                  $display("FAIL ignored_run_result: pass=%b mask=%b cnt=%0d required pass=1 clean",
                           pass, err_mask, err_count);
               end
            end
         end
         if (k == 6) start = 1'b1;
         if (k == 7) start = 1'b0;
         @(negedge clk);
      end
      total++;
      if (first_done !== 20 || n_done !== 1) begin
         bad++;
         $display("FAIL start_ignored: first_done=%0d pulses=%0d required 20 and 1", first_done, n_done);
      end
   endtask

   task automatic test_async_reset();
      int n_done;
      fault_mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      total++;
      if ({a_out, b_out, busy} !== 3'b011 || err_mask === 7'd0) begin
         bad++;
         $display("FAIL pre_abort: ab=%b%b busy=%b mask=%b required ab=01 busy=1 mask nonzero",
                  a_out, b_out, busy, err_mask);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({a_out, b_out, busy, done, pass, err_mask, err_count, first_fail_vec} !== 16'd0) begin
         bad++;
         $display("FAIL async_reset: outputs=%h required 0 before any edge",
                  {a_out, b_out, busy, done, pass, err_mask, err_count, first_fail_vec});
      end
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int k = 0; k < 30; k++) begin
         if (done === 1'b1) n_done++;
         @(negedge clk);
      end
      total++;
      if (n_done !== 0) begin
         bad++;
         $display("FAIL abort_no_done: pulses=%0d required 0", n_done);
      end
      run_check(0, 1'b0, {1'b1, 7'b0000000, 3'd0, 2'd0});
   endtask

   task automatic test_back_to_back();
      int done_at[$];
      logic [12:0] e;
      for (int r = 0; r < 3; r++) exp_q1.push_back({1'b1, 7'b0000000, 3'd0, 2'd0});
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 60 && done_at.size() < 3; k++) begin
         if (done1 === 1'b1) begin
            done_at.push_back(k);
            e = exp_q1.pop_front();
            total++;
            if ({pass1, err_mask1, err_count1, first_fail_vec1} !== e) begin
               bad++;
               $display("FAIL b2b_result run=%0d: pass=%b mask=%b cnt=%0d required pass=1 clean",
                        done_at.size(), pass1, err_mask1, err_count1);
            end
         end
         @(negedge clk);
      end
      start1 = 1'b0;
      total++;
      // First done after 4*(1+1) clocks; each later run adds the DONE cycle and one IDLE cycle.
      if (done_at.size() !== 3 || done_at[0] !== 8 || done_at[1] !== 18 || done_at[2] !== 28) begin
         bad++;
         $display("FAIL b2b_timing: pulses=%0d at %p required 3 at 8,18,28", done_at.size(), done_at);
      end
      repeat (12) @(negedge clk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      total = 0;
      bad = 0;
      fault_mode = 0;
      start = 1'b0;
      start1 = 1'b0;
      rst = 1'b0;
      test_reset();
      test_good_run();
      test_nand_fault();
      test_xor_swap();
      test_start_ignored();
      test_async_reset();
      test_back_to_back();
      total++;
      if (exp_q.size() != 0 || exp_q1.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: left=%0d/%0d required 0/0", exp_q.size(), exp_q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
